// File: rtl/ex_stage.sv
// ex_stage: execute stage of the pipeline.
// Resolves operand forwarding and runs the single-cycle ALU. MUL is handled
// by a 32-iteration shift-add unit that stalls the upstream stages while it
// runs. Results, stored operand B and controls go into the EX/MEM register.
//
// State table
//   state | meaning
//   IDLE  | single-cycle ops flow through; a valid MUL is issued from here
//   BUSY  | one shift-add iteration per cycle, upstream held, EX/MEM gets bubbles
//   DONE  | product complete, written to EX/MEM; ID/EX contents ignored
module ex_stage (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] IdEx_rs_data_i,
    input  logic [31:0] IdEx_rt_data_i,
    input  logic [31:0] IdEx_imm_i,
    input  logic        IdEx_ALUSrc_i,
    input  logic [2:0]  IdEx_ALUCtrl_i,
    input  logic [4:0]  IdEx_rd_i,
    input  logic        IdEx_RegWrite_i,
    input  logic        IdEx_MemtoReg_i,
    input  logic        IdEx_MemRead_i,
    input  logic        IdEx_MemWrite_i,
    input  logic        IdEx_valid_i,
    input  logic [1:0]  ForwardA_i,
    input  logic [1:0]  ForwardB_i,
    input  logic [31:0] MemWb_data_i,
    output logic [31:0] ExMem_ALUResult_o,
    output logic [31:0] ExMem_WriteData_o,
    output logic [4:0]  ExMem_rd_o,
    output logic        ExMem_RegWrite_o,
    output logic        ExMem_MemtoReg_o,
    output logic        ExMem_MemRead_o,
    output logic        ExMem_MemWrite_o,
    output logic        stall_o
);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    // What the EX/MEM register loads this cycle.
    typedef enum logic [1:0] {
        SEL_ALU    = 2'b00,
        SEL_BUBBLE = 2'b01,
        SEL_MUL    = 2'b10
    } exMemSel_t;

    state_t     state;
    state_t     nextState;
    exMemSel_t  exMemSel;

    logic [31:0] fwdA;
    logic [31:0] fwdB;
    logic [31:0] opB;
    logic [31:0] aluResult;
    logic        mulIssue;
    logic [3:0]  idExCtl;

    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [31:0] product;
    logic [4:0]  iterCnt;
    logic [31:0] mulWriteData;
    logic [4:0]  mulRd;
    logic [3:0]  mulCtl;

    assign mulIssue = IdEx_valid_i && (IdEx_ALUCtrl_i == OP_MUL);
    assign idExCtl  = {IdEx_RegWrite_i, IdEx_MemtoReg_i, IdEx_MemRead_i, IdEx_MemWrite_i};

    // Operand A forwarding mux; select 11 falls back to the register value.
    always_comb begin
        case (ForwardA_i)
            FWD_EXMEM: fwdA = ExMem_ALUResult_o;
            FWD_MEMWB: fwdA = MemWb_data_i;
            default:   fwdA = IdEx_rs_data_i;
        endcase
    end

    // Operand B forwarding mux; this value is also the store data.
    always_comb begin
        case (ForwardB_i)
            FWD_EXMEM: fwdB = ExMem_ALUResult_o;
            FWD_MEMWB: fwdB = MemWb_data_i;
            default:   fwdB = IdEx_rt_data_i;
        endcase
    end

    assign opB = IdEx_ALUSrc_i ? IdEx_imm_i : fwdB;

    // Single-cycle ALU; MUL and unused codes produce zero here.
    always_comb begin
        aluResult = 32'd0;
        case (IdEx_ALUCtrl_i)
            OP_AND:  aluResult = fwdA & opB;
            OP_OR:   aluResult = fwdA | opB;
            OP_ADD:  aluResult = fwdA + opB;
            OP_SUB:  aluResult = fwdA - opB;
            OP_SLT:  aluResult = ($signed(fwdA) < $signed(opB)) ? 32'd1 : 32'd0;
            default: aluResult = 32'd0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // FSM next-state logic.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    nextState = mulIssue ? BUSY : IDLE;
            BUSY:    nextState = (iterCnt == 5'd31) ? DONE : BUSY;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // FSM outputs: upstream stall and EX/MEM load source.
    always_comb begin
        stall_o  = 1'b0;
        exMemSel = SEL_ALU;
        case (state)
            IDLE: begin
                if (mulIssue) begin
                    stall_o  = 1'b1;
                    exMemSel = SEL_BUBBLE;
                end
            end
            BUSY: begin
                stall_o  = 1'b1;
                exMemSel = SEL_BUBBLE;
            end
            DONE: begin
                exMemSel = SEL_MUL;
            end
            default: begin
                stall_o  = 1'b0;
                exMemSel = SEL_ALU;
            end
        endcase
    end

    // Shift-add multiplier: operands captured at issue, one iteration per BUSY cycle.
    // Only the low 32 product bits are kept, so the multiplicand is 32 bits wide.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mcand        <= 32'd0;
            mplier       <= 32'd0;
            product      <= 32'd0;
            iterCnt      <= 5'd0;
            mulWriteData <= 32'd0;
            mulRd        <= 5'd0;
            mulCtl       <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (mulIssue) begin
                        mcand        <= fwdA;
                        mplier       <= opB;
                        product      <= 32'd0;
                        iterCnt      <= 5'd0;
                        mulWriteData <= fwdB;
                        mulRd        <= IdEx_rd_i;
                        mulCtl       <= idExCtl;
                    end
                end
                BUSY: begin
                    if (mplier[0]) begin
                        product <= product + mcand;
                    end
                    mcand   <= {mcand[30:0], 1'b0};
                    mplier  <= {1'b0, mplier[31:1]};
                    iterCnt <= iterCnt + 5'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // EX/MEM pipeline register; bubbles clear controls but keep data and rd.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ExMem_ALUResult_o <= 32'd0;
            ExMem_WriteData_o <= 32'd0;
            ExMem_rd_o        <= 5'd0;
            ExMem_RegWrite_o  <= 1'b0;
            ExMem_MemtoReg_o  <= 1'b0;
            ExMem_MemRead_o   <= 1'b0;
            ExMem_MemWrite_o  <= 1'b0;
        end else begin
            case (exMemSel)
                SEL_ALU: begin
                    ExMem_ALUResult_o <= aluResult;
                    ExMem_WriteData_o <= fwdB;
                    ExMem_rd_o        <= IdEx_rd_i;
                    {ExMem_RegWrite_o, ExMem_MemtoReg_o, ExMem_MemRead_o, ExMem_MemWrite_o}
                        <= IdEx_valid_i ? idExCtl : 4'd0;
                end
                SEL_MUL: begin
                    ExMem_ALUResult_o <= product;
                    ExMem_WriteData_o <= mulWriteData;
                    ExMem_rd_o        <= mulRd;
                    {ExMem_RegWrite_o, ExMem_MemtoReg_o, ExMem_MemRead_o, ExMem_MemWrite_o}
                        <= mulCtl;
                end
                default: begin
                    {ExMem_RegWrite_o, ExMem_MemtoReg_o, ExMem_MemRead_o, ExMem_MemWrite_o}
                        <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: scoreboard of expected EX/MEM contents, pushed when an
// instruction is driven and popped when the EX/MEM register is loaded.
module tb_ex_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] IdEx_rs_data_i, IdEx_rt_data_i, IdEx_imm_i;
    logic        IdEx_ALUSrc_i;
    logic [2:0]  IdEx_ALUCtrl_i;
    logic [4:0]  IdEx_rd_i;
    logic        IdEx_RegWrite_i, IdEx_MemtoReg_i, IdEx_MemRead_i, IdEx_MemWrite_i;
    logic        IdEx_valid_i;
    logic [1:0]  ForwardA_i, ForwardB_i;
    logic [31:0] MemWb_data_i;
    logic [31:0] ExMem_ALUResult_o, ExMem_WriteData_o;
    logic [4:0]  ExMem_rd_o;
    logic        ExMem_RegWrite_o, ExMem_MemtoReg_o, ExMem_MemRead_o, ExMem_MemWrite_o;
    logic        stall_o;

    always #5 clk_i = ~clk_i;

    ex_stage dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .IdEx_rs_data_i    (IdEx_rs_data_i),
        .IdEx_rt_data_i    (IdEx_rt_data_i),
        .IdEx_imm_i        (IdEx_imm_i),
        .IdEx_ALUSrc_i     (IdEx_ALUSrc_i),
        .IdEx_ALUCtrl_i    (IdEx_ALUCtrl_i),
        .IdEx_rd_i         (IdEx_rd_i),
        .IdEx_RegWrite_i   (IdEx_RegWrite_i),
        .IdEx_MemtoReg_i   (IdEx_MemtoReg_i),
        .IdEx_MemRead_i    (IdEx_MemRead_i),
        .IdEx_MemWrite_i   (IdEx_MemWrite_i),
        .IdEx_valid_i      (IdEx_valid_i),
        .ForwardA_i        (ForwardA_i),
        .ForwardB_i        (ForwardB_i),
        .MemWb_data_i      (MemWb_data_i),
        .ExMem_ALUResult_o (ExMem_ALUResult_o),
        .ExMem_WriteData_o (ExMem_WriteData_o),
        .ExMem_rd_o        (ExMem_rd_o),
        .ExMem_RegWrite_o  (ExMem_RegWrite_o),
        .ExMem_MemtoReg_o  (ExMem_MemtoReg_o),
        .ExMem_MemRead_o   (ExMem_MemRead_o),
        .ExMem_MemWrite_o  (ExMem_MemWrite_o),
        .stall_o           (stall_o)
    );

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] wd;
        logic [4:0]  rd;
        logic [3:0]  ctl;
    } exp_t;

    exp_t        sbQ[$];
    int          nCompared   = 0;
    int          nMismatched = 0;
    logic [31:0] lastRes     = 32'd0;

    localparam logic [2:0] OP_AND = 3'b000, OP_OR = 3'b001, OP_ADD = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011, OP_SUB = 3'b110, OP_SLT = 3'b111;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] aluModel(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        case (op)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_MUL:  return a * b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] fwdModel(input logic [1:0] sel, input logic [31:0] regVal,
                                             input logic [31:0] memWb);
        case (sel)
            2'b10:   return lastRes;
            2'b01:   return memWb;
            default: return regVal;
        endcase
    endfunction

    function automatic logic [31:0] ctlOut();
        return {28'd0, ExMem_RegWrite_o, ExMem_MemtoReg_o, ExMem_MemRead_o, ExMem_MemWrite_o};
    endfunction

    task automatic stepCycle();
        @(posedge clk_i);
        #1;
    endtask

    // Drive one ID/EX instruction and push its expected EX/MEM contents.
    task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] imm, input logic aluSrc, input logic [1:0] fa,
                         input logic [1:0] fb, input logic [31:0] memWb, input logic [4:0] rd,
                         input logic [3:0] ctl, input logic valid);
        exp_t        e;
        logic [31:0] a, b0, b;
        IdEx_ALUCtrl_i = op;
        IdEx_rs_data_i = rs;
        IdEx_rt_data_i = rt;
        IdEx_imm_i     = imm;
        IdEx_ALUSrc_i  = aluSrc;
        ForwardA_i     = fa;
        ForwardB_i     = fb;
        MemWb_data_i   = memWb;
        IdEx_rd_i      = rd;
        {IdEx_RegWrite_i, IdEx_MemtoReg_i, IdEx_MemRead_i, IdEx_MemWrite_i} = ctl;
        IdEx_valid_i   = valid;
        a  = fwdModel(fa, rs, memWb);
        b0 = fwdModel(fb, rt, memWb);
        b  = aluSrc ? imm : b0;
        e.res = aluModel(op, a, b);
        e.wd  = b0;
        e.rd  = rd;
        e.ctl = valid ? ctl : 4'd0;
        sbQ.push_back(e);
        #1;
    endtask

    task automatic checkOut(input string tag);
        exp_t e;
        checkVal({tag, "_qdepth"}, 32'(sbQ.size()), 32'd1);
        if (sbQ.size() != 0) begin
            e = sbQ.pop_front();
            checkVal({tag, "_res"}, ExMem_ALUResult_o, e.res);
            checkVal({tag, "_wd"}, ExMem_WriteData_o, e.wd);
            checkVal({tag, "_rd"}, 32'(ExMem_rd_o), 32'(e.rd));
            checkVal({tag, "_ctl"}, ctlOut(), 32'(e.ctl));
            lastRes = e.res;
        end
    endtask

    task automatic aluOp(input string tag, input logic [2:0] op, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [31:0] imm, input logic aluSrc,
                         input logic [1:0] fa, input logic [1:0] fb, input logic [31:0] memWb,
                         input logic [4:0] rd, input logic [3:0] ctl, input logic valid);
        issue(op, rs, rt, imm, aluSrc, fa, fb, memWb, rd, ctl, valid);
        checkVal({tag, "_nostall"}, 32'(stall_o), 32'd0);
        stepCycle();
        checkOut(tag);
    endtask

    // Run an already-issued MUL to completion; ID/EX is scrambled while it runs.
    task automatic runMul(input string tag);
        int stallCnt = 0;
        while (stall_o === 1'b1 && stallCnt < 100) begin
            stallCnt++;
            stepCycle();
            checkVal({tag, "_bubble_ctl"}, ctlOut(), 32'd0);
            IdEx_ALUCtrl_i = OP_ADD;
            IdEx_rs_data_i = $urandom;
            IdEx_rt_data_i = $urandom;
            MemWb_data_i   = $urandom;
            ForwardA_i     = 2'($urandom_range(0, 3));
            ForwardB_i     = 2'($urandom_range(0, 3));
            #1;
        end
        checkVal({tag, "_stall_cycles"}, 32'(stallCnt), 32'd33);
        stepCycle();
        checkOut(tag);
    endtask

    initial begin
        rst_i = 1'b1;
        IdEx_rs_data_i = 0; IdEx_rt_data_i = 0; IdEx_imm_i = 0; IdEx_ALUSrc_i = 0;
        IdEx_ALUCtrl_i = OP_ADD; IdEx_rd_i = 0; IdEx_RegWrite_i = 0; IdEx_MemtoReg_i = 0;
        IdEx_MemRead_i = 0; IdEx_MemWrite_i = 0; IdEx_valid_i = 0;
        ForwardA_i = 0; ForwardB_i = 0; MemWb_data_i = 0;
        stepCycle();
        stepCycle();
        checkVal("rst_res", ExMem_ALUResult_o, 32'd0);
        checkVal("rst_wd", ExMem_WriteData_o, 32'd0);
        checkVal("rst_rd", 32'(ExMem_rd_o), 32'd0);
        checkVal("rst_ctl", ctlOut(), 32'd0);
        checkVal("rst_stall", 32'(stall_o), 32'd0);
        rst_i = 1'b0;

        aluOp("add_basic", OP_ADD, 32'd5, 32'd7, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 5'd3, 4'b1000, 1'b1);
        aluOp("add_prior", OP_ADD, 32'h10, 32'd0, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 5'd4, 4'b1000, 1'b1);
        aluOp("sub_fwd", OP_SUB, 32'h999, 32'h888, 32'd0, 1'b0, 2'b10, 2'b01, 32'h3, 5'd5, 4'b1000, 1'b1);
        aluOp("sub_fwd11", OP_SUB, 32'h20, 32'd5, 32'd0, 1'b0, 2'b11, 2'b00, 32'h77, 5'd6, 4'b1000, 1'b1);
        aluOp("slt_neg", OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 5'd7, 4'b1000, 1'b1);
        aluOp("slt_pos", OP_SLT, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 5'd7, 4'b1000, 1'b1);
        aluOp("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'd1, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 5'd8, 4'b1000, 1'b1);
        aluOp("and", OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 5'd9, 4'b1100, 1'b1);
        aluOp("or_store", OP_OR, 32'hF000_0000, 32'h0000_00AB, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 5'd10, 4'b0001, 1'b1);
        aluOp("add_imm", OP_ADD, 32'd10, 32'd99, 32'hFFFF_FFFE, 1'b1, 2'b00, 2'b00, 32'd0, 5'd0, 4'b0110, 1'b1);
        aluOp("bad_op", 3'b100, 32'd3, 32'd4, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 5'd11, 4'b1000, 1'b1);
        aluOp("bubble", OP_ADD, 32'd1, 32'd2, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 5'd12, 4'b1111, 1'b0);

        // Multiply 0x12345 x 0x100, then a back-to-back MUL forwarding the first product.
        issue(OP_MUL, 32'h12345, 32'h100, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 5'd9, 4'b1000, 1'b1);
        checkVal("mul1_stall_issue", 32'(stall_o), 32'd1);
        runMul("mul1");
        issue(OP_MUL, 32'd0, 32'h55, 32'h10, 1'b1, 2'b10, 2'b00, 32'd0, 5'd13, 4'b1000, 1'b1);
        checkVal("mul2_stall_issue", 32'(stall_o), 32'd1);
        runMul("mul2");
        aluOp("after_mul", OP_ADD, 32'd2, 32'd3, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 5'd1, 4'b1000, 1'b1);

        // Reset in the middle of a multiply: nothing of the product may surface.
        issue(OP_MUL, 32'd3, 32'd4, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 5'd14, 4'b1000, 1'b1);
        for (int i = 0; i < 10; i++) stepCycle();
        checkVal("abort_midstall", 32'(stall_o), 32'd1);
        rst_i = 1'b1;
        IdEx_valid_i = 1'b0; IdEx_ALUCtrl_i = OP_ADD;
        IdEx_rs_data_i = 0; IdEx_rt_data_i = 0; ForwardA_i = 0; ForwardB_i = 0;
        stepCycle();
        checkVal("abort_res", ExMem_ALUResult_o, 32'd0);
        checkVal("abort_wd", ExMem_WriteData_o, 32'd0);
        checkVal("abort_rd", 32'(ExMem_rd_o), 32'd0);
        checkVal("abort_ctl", ctlOut(), 32'd0);
        checkVal("abort_stall", 32'(stall_o), 32'd0);
        rst_i = 1'b0;
        sbQ.delete();
        lastRes = 32'd0;
        for (int i = 0; i < 36; i++) begin
            aluOp("abort_idle", OP_ADD, 32'd0, 32'd0, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 5'd0, 4'b1000, 1'b0);
        end

        // Invalid MUL must neither stall nor leak its store control.
        IdEx_ALUCtrl_i = OP_MUL; IdEx_valid_i = 1'b0; IdEx_MemWrite_i = 1'b1;
        IdEx_RegWrite_i = 1'b1;
        #1;
        checkVal("inv_mul_stall", 32'(stall_o), 32'd0);
        stepCycle();
        checkVal("inv_mul_memwrite", 32'(ExMem_MemWrite_o), 32'd0);
        checkVal("inv_mul_regwrite", 32'(ExMem_RegWrite_o), 32'd0);
        checkVal("inv_mul_stall_next", 32'(stall_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 clk_i  in  1  single clock; all state updates on rising edge.
REQ-002 rst_i  in  1  reset, synchronous, active-high.
REQ-003 IdEx_rs_data_i / IdEx_rt_data_i  in  32  register-file operands from ID/EX.
REQ-004 IdEx_imm_i  in  32  sign-extended immediate.
REQ-005 IdEx_ALUSrc_i  in  1  1 = operand B is immediate.
REQ-006 IdEx_ALUCtrl_i  in  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, 011 MUL; other codes yield result 0.
REQ-007 IdEx_rd_i  in  5  destination register.
REQ-008 IdEx_RegWrite_i, IdEx_MemtoReg_i, IdEx_MemRead_i, IdEx_MemWrite_i  in  1 each  control bits passed to EX/MEM.
REQ-009 IdEx_valid_i  in  1  ID/EX holds a real instruction; 0 = bubble.
REQ-010 ForwardA_i / ForwardB_i  in  2  forwarding-unit selects: 00 register, 10 EX/MEM result, 01 MEM/WB data, 11 treated as 00.
REQ-011 MemWb_data_i  in  32  write-back value from MEM/WB.
REQ-012 ExMem_ALUResult_o  out  32  registered result; also the internal source for select 10.
REQ-013 ExMem_WriteData_o  out  32  registered forwarded operand B (before ALUSrc mux) for stores.
REQ-014 ExMem_rd_o  out  5; ExMem_RegWrite_o, ExMem_MemtoReg_o, ExMem_MemRead_o, ExMem_MemWrite_o  out  1 each  registered controls.
REQ-015 stall_o  out  1  combinational; 1 = upstream (PC, IF/ID, ID/EX) must hold.

Function
REQ-016 Operand A = mux(ForwardA_i) over {IdEx_rs_data_i, ExMem_ALUResult_o, MemWb_data_i}; fwdB likewise with ForwardB_i and IdEx_rt_data_i; operand B = IdEx_ALUSrc_i ? IdEx_imm_i : fwdB.
REQ-017 Single-cycle ops: 32-bit two's-complement, wrap-around on overflow, no flags; SLT = signed compare giving 32'd1 or 32'd0.
REQ-018 FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-019 IDLE, non-MUL or IdEx_valid_i=0: EX/MEM loads result, fwdB, rd and controls each cycle; controls forced 0 when IdEx_valid_i=0.
REQ-020 IDLE, IdEx_valid_i=1 and ALUCtrl=MUL: capture operand A, operand B, rd and controls, clear product and 5-bit counter, go BUSY; stall_o=1 this cycle.
REQ-021 BUSY: one shift-add iteration per cycle (product += multiplicand if multiplier LSB set; multiplicand <<1, multiplier >>1); stall_o=1; counter increments; after iteration with counter=31 go DONE.
REQ-022 In IDLE-issue and BUSY cycles EX/MEM loads a bubble: all four control outputs 0, data/rd outputs hold previous values.
REQ-023 DONE: stall_o=0; EX/MEM loads low 32 bits of product, captured fwdB, rd and controls; next state IDLE unconditionally; ID/EX contents ignored this cycle (no re-issue).
REQ-024 MUL latency: issue in cycle N, stall_o high cycles N..N+32, result visible on ExMem_ALUResult_o after edge ending cycle N+33; product low 32 bits, sign irrelevant.
REQ-025 Operands for MUL are sampled only in the issue cycle; forwarding selects during BUSY/DONE have no effect on the product.
REQ-026 Back-to-back MUL: second MUL issues from IDLE in cycle N+34 at earliest.
REQ-027 rd = 0 passes through unchanged; suppression is downstream's responsibility.

Reset
REQ-028 rst_i=1 at an edge: all outputs zero, state IDLE, counter and product zero, next cycle stall_o=0 unless a MUL is presented.
REQ-029 Reset during BUSY or DONE aborts the multiply; no partial result reaches EX/MEM.

Verification
REQ-030 ADD rs=5, rt=7, Forward 00/00 -> ExMem_ALUResult_o=12 one edge later, RegWrite copied.
REQ-031 Prior result 0x10 in EX/MEM, MemWb_data_i=0x3, SUB with ForwardA=10, ForwardB=01 -> result 0xD; ForwardA=11 -> uses rs data.
REQ-032 SLT 0xFFFFFFFF vs 1 -> 1; ADD 0x7FFFFFFF+1 -> 0x80000000.
REQ-033 MUL 0x12345 x 0x100 issued cycle N -> stall_o=1 for exactly 33 cycles, EX/MEM controls 0 meanwhile, result 0x01234500 after edge ending N+33, stall_o=0 in N+33.
REQ-034 rst_i pulse at cycle N+10 of a MUL -> outputs 0, stall_o follows IDLE rule, no product written.
REQ-035 IdEx_valid_i=0 with MemWrite=1, ALUCtrl=MUL -> no stall, ExMem_MemWrite_o=0.
